multicycle_alu: RTL
===================

MULTICYCLE_ALU -- requirements
Module: multicycle_alu

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand and result width; legal values are 8 to 64.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes occur on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port inValid, input, 1 bit: operation request is valid.
REQ-005 The block SHALL have port inReady, output, 1 bit: block can accept a request.
REQ-006 The block SHALL have port inpReadData1, input, WIDTH bits: operand A.
REQ-007 The block SHALL have port inpData2, input, WIDTH bits: operand B.
REQ-008 The block SHALL have port aluControl, input, 3 bits: opcode.
REQ-009 The block SHALL have port outValid, output, 1 bit: result and flags are valid.
REQ-010 The block SHALL have port outReady, input, 1 bit: consumer accepts the result.
REQ-011 The block SHALL have port aluResult, output, WIDTH bits: result.
REQ-012 The block SHALL have ports outZero, outCarry, outOverflow and outDivZero, each output, 1 bit, each a result flag.

Function
REQ-013 Opcode map SHALL be:
- 000 add
- 001 sub (A-B)
- 010 mul (low WIDTH bits, unsigned)
- 011 div (unsigned quotient A/B)
- 100 and
- 101 or
- 110 xor
- 111 pass A
REQ-014 The FSM SHALL have states IDLE, BUSY and DONE; inReady SHALL be 1 only in IDLE, combinationally from the state.
REQ-015 A request SHALL be accepted on an edge where inValid=1 and inReady=1; operands and opcode SHALL be registered at that edge, and inputs are don't-care afterwards.
REQ-016 Ops 000, 001 and 100-111 SHALL go IDLE->DONE at the accept edge, so outValid=1 in the cycle immediately after acceptance (latency 1).
REQ-017 Ops 010 and 011 SHALL go IDLE->BUSY and iterate one bit per cycle for exactly WIDTH cycles, then go to DONE; outValid SHALL rise WIDTH+1 cycles after the accept edge.
REQ-018 Mul SHALL use shift-add and div SHALL use restoring division, with an internal iteration counter of clog2(WIDTH)+1 bits.
REQ-019 In DONE, outValid=1; the state SHALL go DONE->IDLE on the edge where outReady=1.
REQ-020 While outValid=1 and outReady=0, aluResult and all flags SHALL be held stable.
REQ-021 No request SHALL be accepted in the DONE->IDLE transition cycle, giving a minimum issue interval of 2 cycles.
REQ-022 outZero SHALL be 1 iff aluResult==0, for every opcode.
REQ-023 outCarry SHALL be the carry-out of A+B for add, and the carry-out of A+~B+1 for sub (1 = no borrow); it SHALL be 0 for other ops.
REQ-024 outOverflow SHALL be the signed two's-complement overflow for add and sub, and 0 for other ops.
REQ-025 Div with B==0 SHALL produce aluResult all ones and outDivZero=1, with the same WIDTH+1 latency; outDivZero SHALL be 0 in every other case.
REQ-026 Unsigned arithmetic SHALL wrap modulo 2^WIDTH; the high product bits SHALL be discarded.

Reset
REQ-027 At any edge with reset=1, state SHALL become IDLE, and outValid, aluResult, all flags and the iteration counter SHALL become 0.
REQ-028 Reset SHALL take priority over acceptance and iteration, including reset mid-BUSY and reset in DONE; any in-flight result SHALL be discarded.
REQ-029 inReady SHALL be 1 in the first cycle after reset deasserts.

Verification
REQ-030 The bench SHALL cover add, WIDTH=32: A=0x7FFFFFFF, B=1 -> next cycle outValid=1, aluResult=0x80000000, outOverflow=1, outCarry=0, outZero=0.
REQ-031 The bench SHALL cover sub: A=5, B=5 -> aluResult=0, outZero=1, outCarry=1, outOverflow=0; and A=0, B=1 -> 0xFFFFFFFF, outCarry=0.
REQ-032 The bench SHALL cover mul: 123*456 -> outValid exactly 33 cycles after accept, aluResult=56088; and 0x10000*0x10000 -> 0, outZero=1.
REQ-033 The bench SHALL cover div: 100/7 -> aluResult=14 at 33 cycles; and 9/0 -> 0xFFFFFFFF, outDivZero=1.
REQ-034 The bench SHALL cover backpressure: xor 0xF0F0F0F0^0xFFFF0000 with outReady=0 for 3 cycles -> aluResult=0x0F0FF0F0 held, inReady=0 throughout, and IDLE the cycle after outReady=1.
REQ-035 The bench SHALL cover reset mid-div: reset asserted at BUSY cycle 10 -> next cycle outValid=0, inReady=1, and no stale result ever appears.

Source files
------------

// File: rtl/multicycle_alu.sv
// Multicycle ALU: single-cycle logic/add/sub ops, iterative shift-add multiply
// and restoring divide (one bit per cycle), valid/ready handshake on both sides.
module multicycle_alu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inValid,
  output logic             inReady,
  input  logic [WIDTH-1:0] inpReadData1,
  input  logic [WIDTH-1:0] inpData2,
  input  logic [2:0]       aluControl,
  output logic             outValid,
  input  logic             outReady,
  output logic [WIDTH-1:0] aluResult,
  output logic             outZero,
  output logic             outCarry,
  output logic             outOverflow,
  output logic             outDivZero
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] a_reg, b_reg;       // mul: shifting multiplicand/multiplier; div: divisor in b_reg
  logic [WIDTH-1:0] acc_reg;            // mul: partial product; div: partial remainder
  logic [WIDTH-1:0] quo_reg;            // div: dividend shifting out, quotient shifting in
  logic             is_div_reg;
  logic [CW-1:0]    count_reg;
  logic [WIDTH-1:0] result_reg;
  logic             zero_reg, carry_reg, ovf_reg, divzero_reg;

  logic             accept, multi_op;
  logic [WIDTH:0]   sum_ext, diff_ext;
  logic [WIDTH-1:0] quick_res;
  logic             quick_carry, quick_ovf;
  logic [WIDTH-1:0] mul_acc_next;
  logic [WIDTH:0]   rem_shift;
  logic             div_ge;
  logic [WIDTH-1:0] div_acc_next, div_quo_next, final_res;
  logic             iter_last;

  assign accept    = inValid && inReady;
  assign multi_op  = (aluControl[2:1] == 2'b01);
  assign iter_last = (count_reg == LAST_ITER);

  assign sum_ext  = {1'b0, inpReadData1} + {1'b0, inpData2};
  assign diff_ext = {1'b0, inpReadData1} + {1'b0, ~inpData2} + {{WIDTH{1'b0}}, 1'b1};

  // Single-cycle result and flags, computed straight from the request inputs
  always_comb begin
    quick_res   = '0;
    quick_carry = 1'b0;
    quick_ovf   = 1'b0;
    case (aluControl)
      3'b000: begin
        quick_res   = sum_ext[WIDTH-1:0];
        quick_carry = sum_ext[WIDTH];
        quick_ovf   = (inpReadData1[WIDTH-1] == inpData2[WIDTH-1]) &&
                      (sum_ext[WIDTH-1] != inpReadData1[WIDTH-1]);
      end
      3'b001: begin
        quick_res   = diff_ext[WIDTH-1:0];
        quick_carry = diff_ext[WIDTH];
        quick_ovf   = (inpReadData1[WIDTH-1] != inpData2[WIDTH-1]) &&
                      (diff_ext[WIDTH-1] != inpReadData1[WIDTH-1]);
      end
      3'b100:  quick_res = inpReadData1 & inpData2;
      3'b101:  quick_res = inpReadData1 | inpData2;
      3'b110:  quick_res = inpReadData1 ^ inpData2;
      3'b111:  quick_res = inpReadData1;
      default: quick_res = '0;
    endcase
  end

  // One iteration step of shift-add multiply and restoring divide
  always_comb begin
    mul_acc_next = b_reg[0] ? (acc_reg + a_reg) : acc_reg;
    rem_shift    = {acc_reg, quo_reg[WIDTH-1]};
    div_ge       = (rem_shift >= {1'b0, b_reg});
    div_acc_next = div_ge ? (rem_shift[WIDTH-1:0] - b_reg) : rem_shift[WIDTH-1:0];
    div_quo_next = {quo_reg[WIDTH-2:0], div_ge};
    if (is_div_reg)
      final_res = (b_reg == '0) ? '1 : div_quo_next;
    else
      final_res = mul_acc_next;
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept) state_next = multi_op ? BUSY : DONE;
      BUSY:    if (iter_last) state_next = DONE;
      DONE:    if (outReady) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Handshake outputs decoded from state only
  always_comb begin
    inReady  = (state_reg == IDLE);
    outValid = (state_reg == DONE);
  end

  // Operand capture, iteration and result/flag registers; held while in DONE
  always_ff @(posedge clk) begin
    if (reset) begin
      a_reg       <= '0;
      b_reg       <= '0;
      acc_reg     <= '0;
      quo_reg     <= '0;
      is_div_reg  <= 1'b0;
      count_reg   <= '0;
      result_reg  <= '0;
      zero_reg    <= 1'b0;
      carry_reg   <= 1'b0;
      ovf_reg     <= 1'b0;
      divzero_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: if (accept) begin
          a_reg      <= inpReadData1;
          b_reg      <= inpData2;
          quo_reg    <= inpReadData1;
          acc_reg    <= '0;
          is_div_reg <= aluControl[0];
          count_reg  <= '0;
          if (!multi_op) begin
            result_reg  <= quick_res;
            zero_reg    <= (quick_res == '0);
            carry_reg   <= quick_carry;
            ovf_reg     <= quick_ovf;
            divzero_reg <= 1'b0;
          end
        end
        BUSY: begin
          count_reg <= count_reg + 1'b1;
          if (is_div_reg) begin
            acc_reg <= div_acc_next;
            quo_reg <= div_quo_next;
          end else begin
            acc_reg <= mul_acc_next;
            a_reg   <= a_reg << 1;
            b_reg   <= b_reg >> 1;
          end
          if (iter_last) begin
            result_reg  <= final_res;
            zero_reg    <= (final_res == '0);
            carry_reg   <= 1'b0;
            ovf_reg     <= 1'b0;
            divzero_reg <= is_div_reg && (b_reg == '0);
          end
        end
        default: ;
      endcase
    end
  end

  assign aluResult   = result_reg;
  assign outZero     = zero_reg;
  assign outCarry    = carry_reg;
  assign outOverflow = ovf_reg;
  assign outDivZero  = divzero_reg;

endmodule
